// File: rtl/echo_delay.sv
// Feedback echo stage: mixes each offset-binary sample with an attenuated copy
// from delay_len samples earlier, held in a circular on-chip buffer.
`timescale 1ns/1ps

module echo_delay #(
  parameter int DATA_W   = 12,
  parameter int ADDR_W   = 10,
  parameter int FB_SHIFT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] delay_len,
  input  logic              bypass,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              overrun
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic signed [DATA_W-1:0] S_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_READ,
    S_MIX,
    S_WRITE
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0]        clr_cnt;
  logic [ADDR_W-1:0]        wptr;
  logic [ADDR_W-1:0]        raddr;
  logic signed [DATA_W-1:0] x_q;
  logic signed [DATA_W-1:0] rd_data;
  logic signed [DATA_W-1:0] d_q;
  logic                     len_zero_q;
  logic                     bypass_q;

  logic signed [DATA_W-1:0] fb;
  logic signed [DATA_W:0]   sum;
  logic signed [DATA_W-1:0] sat;
  logic signed [DATA_W-1:0] wdata;

  logic                     ram_we;
  logic [ADDR_W-1:0]        ram_waddr;
  logic signed [DATA_W-1:0] ram_wdata;
  logic signed [DATA_W-1:0] mem [DEPTH];

  // ---------------------------------------------------------------- FSM
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) state <= S_INIT;
    else       state <= state_nxt;
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_INIT:  if (clr_cnt == {ADDR_W{1'b1}}) state_nxt = S_IDLE;
      S_IDLE:  if (in_valid) state_nxt = S_READ;
      S_READ:  state_nxt = S_MIX;
      S_MIX:   state_nxt = S_WRITE;
      S_WRITE: state_nxt = S_IDLE;
      default: state_nxt = S_INIT;
    endcase
  end

  assign busy = (state != S_IDLE);

  // ------------------------------------------------------ control / outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      clr_cnt   <= '0;
      wptr      <= '0;
      out_valid <= 1'b0;
      out_data  <= {1'b1, {(DATA_W-1){1'b0}}};
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid && state != S_IDLE) overrun <= 1'b1;
      if (state == S_INIT) clr_cnt <= clr_cnt + 1'b1;
      if (state == S_WRITE) begin
        out_valid <= 1'b1;
        out_data  <= {~wdata[DATA_W-1], wdata[DATA_W-2:0]};
        wptr      <= wptr + 1'b1;
      end
    end
  end

  // ------------------------------------------------------ sample capture
  // Captured operands need no reset: they are always reloaded before use.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && in_valid) begin
      x_q        <= {~in_data[DATA_W-1], in_data[DATA_W-2:0]};
      raddr      <= wptr - delay_len;
      len_zero_q <= (delay_len == '0);
      bypass_q   <= bypass;
    end
    if (state == S_MIX) d_q <= len_zero_q ? '0 : rd_data;
  end

  // ------------------------------------------------------ mix and saturate
  always_comb begin
    fb  = d_q >>> FB_SHIFT;
    sum = {x_q[DATA_W-1], x_q} + {fb[DATA_W-1], fb};
    if (sum[DATA_W] != sum[DATA_W-1]) sat = sum[DATA_W] ? S_MIN : S_MAX;
    else                              sat = sum[DATA_W-1:0];
    wdata = bypass_q ? x_q : sat;
  end

  // ------------------------------------------------------ delay buffer RAM
  assign ram_we    = !reset && (state == S_INIT || state == S_WRITE);
  assign ram_waddr = (state == S_INIT) ? clr_cnt : wptr;
  assign ram_wdata = (state == S_INIT) ? '0 : wdata;

  // NOTE: the RAM array has no reset; INIT clears it by writing every address.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    rd_data <= mem[raddr];
  end

endmodule

// File: tb/tb_echo_delay.sv
// Self-checking bench for echo_delay: directed vector table, multi-cycle
// corner sequences and random traffic against an arithmetic reference model.
`timescale 1ns/1ps

module tb_echo_delay;

  localparam int DATA_W   = 12;
  localparam int ADDR_W   = 10;
  localparam int FB_SHIFT = 1;
  localparam int DEPTH    = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [ADDR_W-1:0] delay_len;
  logic              bypass;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic              overrun;

  echo_delay #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FB_SHIFT(FB_SHIFT)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .delay_len(delay_len),
    .bypass   (bypass),
    .out_valid(out_valid),
    .out_data (out_data),
    .busy     (busy),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int errors   = 0;
  int ov_count = 0;

  always @(negedge clk) if (out_valid) ov_count++;

  // Reference model: plain integer arithmetic over a history array.
  int m_mem [DEPTH];
  int m_wptr;

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
    m_wptr = 0;
  endfunction

  function automatic logic [DATA_W-1:0] model_step(input logic [DATA_W-1:0] din,
                                                   input int len, input bit byp);
    int x, d, s;
    x = int'(din) - 2048;
    d = (len == 0) ? 0 : m_mem[(m_wptr - len + DEPTH) % DEPTH];
    s = x + (d >>> FB_SHIFT);
    if (s > 2047)  s = 2047;
    if (s < -2048) s = -2048;
    m_mem[m_wptr] = byp ? x : s;
    m_wptr = (m_wptr + 1) % DEPTH;
    return byp ? din : DATA_W'(s + 2048);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // mode 0: wait for INIT to end; 1: also check outputs every INIT cycle;
  // 2: return right after reset is released. Caller must be at a negedge.
  task automatic do_reset(input int mode);
    int cnt;
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    if (mode == 2) return;
    cnt = 0;
    while (busy && cnt < 1100) begin
      if (mode == 1) begin
        check("init_out_data", out_data, 32'h800);
        check("init_out_valid", out_valid, 0);
        check("init_overrun", overrun, 0);
      end
      cnt++;
      @(negedge clk);
    end
    if (mode == 1) check("init_busy_cycles", cnt, 1024);
    else           check("init_done", busy, 0);
  endtask

  // One sample through the DUT; returns at the negedge inside the out_valid cycle.
  task automatic send(input logic [DATA_W-1:0] din, input logic [ADDR_W-1:0] len,
                      input bit byp, output logic [DATA_W-1:0] got);
    int w, lat;
    w = 0;
    while (busy && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (busy) check("send_idle_timeout", busy, 0);
    in_valid  = 1'b1;
    in_data   = din;
    delay_len = len;
    bypass    = byp;
    @(negedge clk);
    in_valid  = 1'b0;
    delay_len = ADDR_W'($urandom);
    bypass    = ~byp;
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 3);
    check("idle_at_out_valid", busy, 0);
    got = out_data;
  endtask

  typedef struct {
    bit                rst;
    logic [DATA_W-1:0] din;
    logic [ADDR_W-1:0] len;
    bit                byp;
    logic [DATA_W-1:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit rst, input logic [DATA_W-1:0] din,
                              input logic [ADDR_W-1:0] len, input bit byp,
                              input logic [DATA_W-1:0] exp);
    vec_t v;
    v.rst = rst; v.din = din; v.len = len; v.byp = byp; v.exp = exp;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [DATA_W-1:0] got, exp, din;
    logic [ADDR_W-1:0] len;
    bit                byp;
    int                v0, r;

    reset = 1'b1; in_valid = 1'b0; in_data = '0; delay_len = '0; bypass = 1'b0;

    // Echo decay with delay 4: feedback halves each pass.
    add(1, 12'hC00, 10'd4, 0, 12'hC00);
    for (int i = 1; i <= 12; i++)
      add(0, 12'h800, 10'd4, 0, (i == 4) ? 12'hA00 : (i == 8) ? 12'h900 :
                                 (i == 12) ? 12'h880 : 12'h800);
    // Saturation at both rails.
    add(1, 12'hFFF, 10'd1, 0, 12'hFFF);
    add(0, 12'hFFF, 10'd1, 0, 12'hFFF);
    add(0, 12'hFFF, 10'd1, 0, 12'hFFF);
    add(1, 12'h000, 10'd1, 0, 12'h000);
    add(0, 12'h000, 10'd1, 0, 12'h000);
    add(0, 12'h000, 10'd1, 0, 12'h000);
    // Echo disabled and dry passthrough.
    add(0, 12'h123, 10'd0, 0, 12'h123);
    add(0, 12'hABC, 10'd0, 0, 12'hABC);
    add(0, 12'hABC, 10'd4, 1, 12'hABC);
    add(0, 12'h123, 10'd1, 1, 12'h123);

    @(negedge clk);
    do_reset(1);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset(0);
      send(vecs[i].din, vecs[i].len, vecs[i].byp, got);
      void'(model_step(vecs[i].din, int'(vecs[i].len), vecs[i].byp));
      check($sformatf("vec%0d", i), got, vecs[i].exp);
    end

    // Wrap-around: echo of sample 1000 lands on output 1100 after wptr wraps.
    do_reset(0);
    for (int i = 0; i <= 1100; i++) begin
      din = (i == 1000) ? 12'hC00 : 12'h800;
      if (i == 1100) check("wrap_wptr", dut.wptr, 76);
      send(din, 10'd100, 0, got);
      exp = model_step(din, 100, 0);
      check("wrap_model", got, exp);
      if (i == 1100) check("wrap_echo", got, 12'hA00);
    end

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      r   = $urandom_range(0, 3);
      len = (r == 0) ? 10'd0 : (r == 1) ? ADDR_W'($urandom_range(1, 8))
                                        : ADDR_W'($urandom_range(1, DEPTH - 1));
      byp = ($urandom_range(0, 7) == 0);
      din = DATA_W'($urandom);
      send(din, len, byp, got);
      exp = model_step(din, int'(len), byp);
      check("random", got, exp);
    end

    // Two back-to-back strobes: second is dropped and flagged.
    do_reset(0);
    check("overrun_clear", overrun, 0);
    v0 = ov_count;
    in_valid = 1'b1; in_data = 12'h3A5; delay_len = 10'd2; bypass = 1'b0;
    @(negedge clk);
    in_data = 12'h5A3;
    @(negedge clk);
    in_valid = 1'b0;
    exp = model_step(12'h3A5, 2, 0);
    repeat (8) @(negedge clk);
    check("b2b_out_count", ov_count - v0, 1);
    check("b2b_overrun", overrun, 1);
    check("b2b_data", out_data, exp);

    // Strobes during INIT: dropped, no output, overrun set.
    @(negedge clk);
    do_reset(2);
    v0 = ov_count;
    repeat (5) @(negedge clk);
    in_valid = 1'b1; in_data = 12'h777;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (200) @(negedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    r = 0;
    while (busy && r < 1100) begin
      @(negedge clk);
      r++;
    end
    check("init_strobe_done", busy, 0);
    repeat (4) @(negedge clk);
    check("init_strobe_no_out", ov_count - v0, 0);
    check("init_strobe_overrun", overrun, 1);

    // Reset while the sample sits in MIX: no output, full INIT restart.
    v0 = ov_count;
    in_valid = 1'b1; in_data = 12'hC00; delay_len = 10'd4; bypass = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("mid_mix_state", dut.state, 3);
    do_reset(1);
    repeat (6) @(negedge clk);
    check("mid_mix_no_out", ov_count - v0, 0);
    check("mid_mix_overrun", overrun, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
